// File: rtl/branch_update_queue_if.sv
// Bundle of ROB, predictor and fetch signals around the branch update queue.
// The bu_stat_* counters exist only when BR_STATS_EN is defined.
interface branch_update_queue_if;
  logic        rob_to_bu_valid;
  logic [31:0] rob_to_bu_pc;
  logic        rob_to_bu_actual_br;
  logic        rob_to_bu_pred_br;
  logic [31:0] rob_to_bu_next_pc;
  logic        bu_to_rob_full;
  logic        bp_to_bu_stall;
  logic        bu_to_bp_ready;
  logic [31:0] bu_to_bp_pc;
  logic        bu_to_bp_actual_br;
  logic        bu_to_if_redirect;
  logic [31:0] bu_to_if_redirect_pc;
  logic        bu_to_all_clear;
`ifdef BR_STATS_EN
  logic [31:0] bu_stat_total;
  logic [31:0] bu_stat_mispred;
`endif

  // The queue itself sits on the slave side.
  modport slave (
    input  rob_to_bu_valid,
    input  rob_to_bu_pc,
    input  rob_to_bu_actual_br,
    input  rob_to_bu_pred_br,
    input  rob_to_bu_next_pc,
    input  bp_to_bu_stall,
`ifdef BR_STATS_EN
    output bu_stat_total,
    output bu_stat_mispred,
`endif
    output bu_to_rob_full,
    output bu_to_bp_ready,
    output bu_to_bp_pc,
    output bu_to_bp_actual_br,
    output bu_to_if_redirect,
    output bu_to_if_redirect_pc,
    output bu_to_all_clear
  );

  modport master (
    output rob_to_bu_valid,
    output rob_to_bu_pc,
    output rob_to_bu_actual_br,
    output rob_to_bu_pred_br,
    output rob_to_bu_next_pc,
    output bp_to_bu_stall,
`ifdef BR_STATS_EN
    input  bu_stat_total,
    input  bu_stat_mispred,
`endif
    input  bu_to_rob_full,
    input  bu_to_bp_ready,
    input  bu_to_bp_pc,
    input  bu_to_bp_actual_br,
    input  bu_to_if_redirect,
    input  bu_to_if_redirect_pc,
    input  bu_to_all_clear
  );
endinterface

// File: rtl/branch_update_queue.sv
// Buffers committed branches from the ROB and trains the BHT one entry per cycle in order;
// pulses redirect/clear on accepted mispredicts. BR_STATS_EN adds accept/mispredict counters.
module branch_update_queue #(
  parameter int QUEUE_WIDTH = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  branch_update_queue_if.slave bu
);
  localparam int DEPTH = 2 ** QUEUE_WIDTH;
  localparam logic [QUEUE_WIDTH:0] DEPTH_CNT = (QUEUE_WIDTH + 1)'(DEPTH);

  logic [31:0]            pc_mem  [DEPTH];
  logic                   act_mem [DEPTH];
  logic [QUEUE_WIDTH-1:0] head_q, head_d;
  logic [QUEUE_WIDTH-1:0] tail_q, tail_d;
  logic [QUEUE_WIDTH:0]   count_q, count_d;
  logic                   redirect_q, redirect_d;
  logic                   clear_q, clear_d;
  logic [31:0]            redirect_pc_q, redirect_pc_d;
  logic                   full;
  logic                   not_empty;
  logic                   enq;
  logic                   deq;
  logic                   mispredict;

  // Full is taken from registered count only, so a same-cycle dequeue never frees a slot.
  assign full       = (count_q == DEPTH_CNT);
  assign not_empty  = (count_q != '0);
  assign enq        = rdy_in && bu.rob_to_bu_valid && !full;
  assign deq        = rdy_in && not_empty && !bu.bp_to_bu_stall;
  assign mispredict = (bu.rob_to_bu_actual_br != bu.rob_to_bu_pred_br);

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    redirect_d    = redirect_q;
    clear_d       = clear_q;
    redirect_pc_d = redirect_pc_q;
    if (enq) begin
      tail_d = tail_q + QUEUE_WIDTH'(1);
    end
    if (deq) begin
      head_d = head_q + QUEUE_WIDTH'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + (QUEUE_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (QUEUE_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
    // While frozen the pulse registers keep whatever they held.
    if (rdy_in) begin
      redirect_d = enq && mispredict;
      clear_d    = enq && mispredict;
      if (enq && mispredict) begin
        redirect_pc_d = bu.rob_to_bu_next_pc;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      clear_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      clear_q       <= clear_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Entry storage carries no reset; empty-queue outputs are masked by count instead.
  always_ff @(posedge clk_in) begin
    if (enq) begin
      pc_mem[tail_q]  <= bu.rob_to_bu_pc;
      act_mem[tail_q] <= bu.rob_to_bu_actual_br;
    end
  end

  assign bu.bu_to_rob_full       = full;
  assign bu.bu_to_bp_ready       = deq;
  assign bu.bu_to_bp_pc          = not_empty ? pc_mem[head_q] : 32'd0;
  assign bu.bu_to_bp_actual_br   = not_empty ? act_mem[head_q] : 1'b0;
  assign bu.bu_to_if_redirect    = redirect_q;
  assign bu.bu_to_if_redirect_pc = redirect_pc_q;
  assign bu.bu_to_all_clear      = clear_q;

`ifdef BR_STATS_EN
  logic [31:0] stat_total_q, stat_total_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_total_d   = stat_total_q;
    stat_mispred_d = stat_mispred_q;
    if (enq) begin
      stat_total_d = stat_total_q + 32'd1;
      if (mispredict) begin
        stat_mispred_d = stat_mispred_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_total_q   <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_total_q   <= stat_total_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign bu.bu_stat_total   = stat_total_q;
  assign bu.bu_stat_mispred = stat_mispred_q;
`endif
endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench for branch_update_queue: directed cases followed by random traffic,
// checked against a queue-based model of the accepted-branch stream.
module tb_branch_update_queue;
  localparam int QW    = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        act;
  } upd_t;

  typedef struct packed {
    logic        ready;
    logic        full;
    logic        nonempty;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] tot;
    logic [31:0] mis;
  } cyc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b0;

  int checks = 0;
  int passed = 0;

  upd_t upd_q[$];
  cyc_t cyc_q[$];

  int          m_count;
  logic        m_redir;
  logic [31:0] m_rpc;
  logic [31:0] m_tot;
  logic [31:0] m_mis;

  always #5 clk = ~clk;

  branch_update_queue_if bif ();

  branch_update_queue #(.QUEUE_WIDTH(QW)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .rdy_in  (rdy),
    .bu      (bif)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    cyc_q.delete();
    upd_q.delete();
    m_count = 0;
    m_redir = 1'b0;
    m_rpc   = '0;
    m_tot   = '0;
    m_mis   = '0;
  endtask

  // One clock of stimulus: records what this cycle should look like, then applies the edge.
  task automatic drive(input logic v, input logic [31:0] pc, input logic act, input logic pred,
                       input logic [31:0] npc, input logic st, input logic r, output logic accepted);
    cyc_t e;
    upd_t u;
    logic enq;
    logic deq;
    @(posedge clk);
    #1;
    rdy                     = r;
    bif.rob_to_bu_valid     = v;
    bif.rob_to_bu_pc        = pc;
    bif.rob_to_bu_actual_br = act;
    bif.rob_to_bu_pred_br   = pred;
    bif.rob_to_bu_next_pc   = npc;
    bif.bp_to_bu_stall      = st;
    e.full     = (m_count == DEPTH);
    e.nonempty = (m_count != 0);
    e.ready    = r && (m_count != 0) && !st;
    e.redir    = m_redir;
    e.rpc      = m_rpc;
    e.tot      = m_tot;
    e.mis      = m_mis;
    cyc_q.push_back(e);
    enq = r && v && !e.full;
    deq = e.ready;
    if (enq) begin
      u.pc  = pc;
      u.act = act;
      upd_q.push_back(u);
      m_tot = m_tot + 1;
      if (act != pred) begin
        m_mis = m_mis + 1;
        m_rpc = npc;
      end
    end
    if (r) m_redir = enq && (act != pred);
    m_count = m_count + (enq ? 1 : 0) - (deq ? 1 : 0);
    accepted = enq;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, a);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_full"}, 32'(bif.bu_to_rob_full), 32'd0);
    chk({tag, "_ready"}, 32'(bif.bu_to_bp_ready), 32'd0);
    chk({tag, "_bp_pc"}, bif.bu_to_bp_pc, 32'd0);
    chk({tag, "_bp_act"}, 32'(bif.bu_to_bp_actual_br), 32'd0);
    chk({tag, "_redirect"}, 32'(bif.bu_to_if_redirect), 32'd0);
    chk({tag, "_redirect_pc"}, bif.bu_to_if_redirect_pc, 32'd0);
    chk({tag, "_clear"}, 32'(bif.bu_to_all_clear), 32'd0);
  endtask

  // Asserted mid-cycle, after the monitor has consumed this cycle's expectation.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n               = 1'b0;
    bif.rob_to_bu_valid = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every cycle, pops an expected update whenever the DUT offers one.
  initial begin
    cyc_t e;
    upd_t u;
    forever begin
      @(negedge clk);
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        chk("bp_ready", 32'(bif.bu_to_bp_ready), 32'(e.ready));
        chk("full", 32'(bif.bu_to_rob_full), 32'(e.full));
        chk("redirect", 32'(bif.bu_to_if_redirect), 32'(e.redir));
        chk("clear", 32'(bif.bu_to_all_clear), 32'(e.redir));
        chk("redirect_pc", bif.bu_to_if_redirect_pc, e.rpc);
`ifdef BR_STATS_EN
        chk("stat_total", bif.bu_stat_total, e.tot);
        chk("stat_mispred", bif.bu_stat_mispred, e.mis);
`endif
        if (!e.nonempty) begin
          chk("empty_bp_pc", bif.bu_to_bp_pc, 32'd0);
          chk("empty_bp_act", 32'(bif.bu_to_bp_actual_br), 32'd0);
        end
        if (bif.bu_to_bp_ready) begin
          if (upd_q.size() == 0) begin
            checks++;
            $display("FAIL spurious_update: got pc %h expected no update at %0t",
                     bif.bu_to_bp_pc, $time);
          end else begin
            u = upd_q.pop_front();
            $display("update pc=%h act=%b", bif.bu_to_bp_pc, bif.bu_to_bp_actual_br);
            chk("bp_pc", bif.bu_to_bp_pc, u.pc);
            chk("bp_act", 32'(bif.bu_to_bp_actual_br), 32'(u.act));
          end
        end
      end
    end
  end

  initial begin
    logic a;
    int   tries;
    model_reset();
    bif.rob_to_bu_valid     = 1'b0;
    bif.rob_to_bu_pc        = '0;
    bif.rob_to_bu_actual_br = 1'b0;
    bif.rob_to_bu_pred_br   = 1'b0;
    bif.rob_to_bu_next_pc   = '0;
    bif.bp_to_bu_stall      = 1'b0;
    rdy                     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #1;
    rst_n = 1'b1;

    // Reset in the middle of traffic, including a pending redirect.
    drive(1'b1, 32'h1000, 1'b1, 1'b1, 32'h1100, 1'b1, 1'b1, a);
    drive(1'b1, 32'h1004, 1'b0, 1'b1, 32'h1008, 1'b1, 1'b1, a);
    drive(1'b1, 32'h1008, 1'b1, 1'b0, 32'h2000, 1'b1, 1'b1, a);
    mid_reset();
    idle(3);

    // Correct prediction, then mispredict.
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h180, 1'b0, 1'b1, a);
    idle(2);
    drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h204, 1'b0, 1'b1, a);
    idle(3);

    // Fill under stall; the fifth entry (a mispredict) must wait without redirecting.
    for (int i = 1; i <= 4; i++)
      drive(1'b1, 32'(i * 16), 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, a);
    drive(1'b1, 32'h50, 1'b1, 1'b0, 32'h5000, 1'b1, 1'b1, a);
    drive(1'b1, 32'h50, 1'b1, 1'b0, 32'h5000, 1'b1, 1'b1, a);
    tries = 0;
    do begin
      drive(1'b1, 32'h50, 1'b1, 1'b0, 32'h5000, 1'b0, 1'b1, a);
      tries++;
    end while (!a && tries < 8);
    idle(7);

    // Freeze with a non-empty queue and a valid entry offered.
    drive(1'b1, 32'h300, 1'b0, 1'b1, 32'h304, 1'b1, 1'b1, a);
    drive(1'b1, 32'h310, 1'b1, 1'b1, 32'h390, 1'b1, 1'b1, a);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h320, 1'b1, 1'b0, 32'h3200, 1'b0, 1'b0, a);
    idle(4);

    // Five accepted entries, two of them mispredicted, from a clean reset.
    mid_reset();
    drive(1'b1, 32'h400, 1'b1, 1'b1, 32'h480, 1'b0, 1'b1, a);
    drive(1'b1, 32'h404, 1'b0, 1'b1, 32'h408, 1'b0, 1'b1, a);
    drive(1'b1, 32'h408, 1'b0, 1'b0, 32'h40c, 1'b0, 1'b1, a);
    drive(1'b1, 32'h40c, 1'b1, 1'b0, 32'h600, 1'b0, 1'b1, a);
    drive(1'b1, 32'h410, 1'b1, 1'b1, 32'h700, 1'b0, 1'b1, a);
    idle(2);
`ifdef BR_STATS_EN
    chk("stats5_total", bif.bu_stat_total, 32'd5);
    chk("stats5_mispred", bif.bu_stat_mispred, 32'd2);
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 9) < 6), $urandom & 32'hffff_fffc, 1'($urandom),
            1'($urandom), $urandom & 32'hffff_fffc, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) != 0), a);
    end

    tries = 0;
    while (upd_q.size() != 0 && tries < 50) begin
      idle(1);
      tries++;
    end
    idle(1);
    @(negedge clk);
    #1;
    chk("drained", 32'(upd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
